// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream for fifo_burst_reader.
// master = the reader; slave = FIFO model and stream sink.
interface fifo_burst_reader_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_data_out,
        input  fifo_empty,
        input  fifo_underflow,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_data_out,
        output fifo_empty,
        output fifo_underflow,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops burst_len words from a 1-cycle-latency FIFO.
// Optional FIFO_RD_UNDERFLOW_CHK_EN adds sticky err_underflow and err_cnt.
module fifo_burst_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] rd_count,
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    output logic                          err_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   err_cnt,
`endif
    fifo_burst_reader_if.master          bus
);

    if (FIFO_DEPTH < 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [LEN_W-1:0]      rd_count_q, rd_count_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] buf_q [2];
    logic [FIFO_WIDTH-1:0] buf_d [2];
    logic                  head_q, head_d;
    logic [1:0]            cnt_q, cnt_d;

    logic       pop;
    logic       last;
    logic       rd_en;
    logic       tail;
    logic       accept;
    logic [2:0] occ;

    assign pop    = (cnt_q != 2'd0) && bus.m_ready;
    assign last   = (cnt_q != 2'd0) && (rd_count_q == len_q - 1'b1);
    assign accept = (state_q == IDLE) && start && (burst_len != '0);

    // Occupancy the buffer will have once in-flight data lands and the pop retires.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign rd_en = (state_q == RUN) && !bus.fifo_empty
                && (remaining_q != '0) && (occ < 3'd2);

    // An in-flight word implies at most one buffered entry, so tail is free.
    assign tail = head_q ^ cnt_q[0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (rd_en && remaining_q == LEN_W'(1)) state_d = DRAIN;
            DRAIN:   if (pop && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        remaining_d = remaining_q;
        rd_count_d  = rd_count_q;
        len_d       = len_q;
        buf_d       = buf_q;
        head_d      = head_q;
        cnt_d       = cnt_q;

        if (accept) begin
            remaining_d = burst_len;
            len_d       = burst_len;
            rd_count_d  = '0;
        end else begin
            if (rd_en) remaining_d = remaining_q - 1'b1;
            if (pop) rd_count_d = rd_count_q + 1'b1;
        end

        if (inflight_q) buf_d[tail] = bus.fifo_data_out;
        if (pop) head_d = ~head_q;
        cnt_d = occ[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_count_q  <= '0;
            len_q       <= '0;
            inflight_q  <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_count_q  <= rd_count_d;
            len_q       <= len_d;
            inflight_q  <= rd_en;
            buf_q       <= buf_d;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    localparam int ERR_W = $clog2(FIFO_DEPTH) + 1;

    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (inflight_q && bus.fifo_underflow) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_underflow = err_q;
    assign err_cnt       = err_cnt_q;
`endif

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign rd_count    = rd_count_q;
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid = (cnt_q != 2'd0);
    assign bus.m_data  = buf_q[head_q];
    assign bus.m_last  = last;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 1-cycle-latency FIFO.
// Define FIFO_RD_UNDERFLOW_CHK_EN to also exercise the underflow checker.
module tb_fifo_burst_reader;

    localparam int W = 16;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L-1:0] burst_len;
    logic         busy;
    logic         done;
    logic [L-1:0] rd_count;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    logic         err_underflow;
    logic [3:0]   err_cnt;
`endif

    fifo_burst_reader_if #(.FIFO_WIDTH(W)) bus ();

    fifo_burst_reader #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(8),
        .LEN_W(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .burst_len(burst_len),
        .busy(busy),
        .done(done),
        .rd_count(rd_count),
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
        .err_underflow(err_underflow),
        .err_cnt(err_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] pop_d [$];
    logic         pop_l [$];
    int           pop_c [$];
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           rden_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    assign bus.fifo_empty = (fifo_q.size() == 0);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fifo_q.size() != 0)
            bus.fifo_data_out <= fifo_q.pop_front();
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.m_valid && bus.m_ready) begin
            pop_d.push_back(bus.m_data);
            pop_l.push_back(bus.m_last);
            pop_c.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.fifo_rd_en) rden_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [W-1:0] v0, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(v0 + W'(i));
    endtask

    task automatic pulse_start(input logic [L-1:0] len);
        start     = 1'b1;
        burst_len = len;
        @(negedge clk);
        start     = 1'b0;
        burst_len = '0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_burst(input string tag, input int base, input int n,
                             input logic [W-1:0] v0);
        int got_n = pop_d.size() - base;
        chk({tag, "_count"}, got_n, n);
        for (int i = 0; i < n && i < got_n; i++) begin
            chk({tag, "_data"}, pop_d[base+i], v0 + W'(i));
            chk({tag, "_last"}, pop_l[base+i], (i == n - 1));
        end
    endtask

    initial begin
        int base;
        int d0;
        int r0;
        int n;

        rst = 1'b1;
        start = 1'b0;
        burst_len = '0;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;
        bus.fifo_data_out = '0;
        cycles(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", bus.fifo_rd_en, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_rdcnt", rd_count, 0);
        chk("rst_data", bus.m_data, 0);
        rst = 1'b0;
        cycles(1);

        // back-to-back
        preload(16'h0001, 8);
        bus.m_ready = 1'b1;
        base = pop_d.size();
        d0 = done_cnt;
        r0 = rden_cnt;
        pulse_start(16'd8);
        chk("b2b_busy", busy, 1);
        chk("b2b_rden_first", bus.fifo_rd_en, 1);
        wait_done(d0);
        cycles(1);
        chk_burst("b2b", base, 8, 16'h0001);
        if (pop_d.size() - base == 8) begin
            chk("b2b_consec", pop_c[base+7] - pop_c[base], 7);
            chk("b2b_done_lat", done_cyc - pop_c[base+7], 1);
        end
        chk("b2b_rdcnt", rd_count, 8);
        chk("b2b_rden_total", rden_cnt - r0, 8);
        chk("b2b_idle", busy, 0);

        // backpressure
        preload(16'h0001, 4);
        bus.m_ready = 1'b0;
        base = pop_d.size();
        d0 = done_cnt;
        r0 = rden_cnt;
        pulse_start(16'd4);
        cycles(4);
        chk("bp_rden_cnt", rden_cnt - r0, 2);
        chk("bp_rden_low", bus.fifo_rd_en, 0);
        chk("bp_valid", bus.m_valid, 1);
        chk("bp_hold", bus.m_data, 16'h0001);
        cycles(1);
        chk("bp_hold2", bus.m_data, 16'h0001);
        chk("bp_last_lo", bus.m_last, 0);
        bus.m_ready = 1'b1;
        wait_done(d0);
        cycles(1);
        chk_burst("bp", base, 4, 16'h0001);
        chk("bp_rdcnt", rd_count, 4);

        // empty stall
        preload(16'h0011, 2);
        base = pop_d.size();
        d0 = done_cnt;
        r0 = rden_cnt;
        pulse_start(16'd5);
        cycles(10);
        chk("stall_busy", busy, 1);
        chk("stall_rden", bus.fifo_rd_en, 0);
        chk("stall_rden_cnt", rden_cnt - r0, 2);
        chk("stall_rdcnt", rd_count, 2);
        preload(16'h0013, 3);
        wait_done(d0);
        cycles(5);
        chk_burst("stall", base, 5, 16'h0011);
        chk("stall_done_once", done_cnt - d0, 1);

        // ignored requests
        pulse_start(16'd0);
        chk("ign_zero_busy", busy, 0);
        chk("ign_zero_rdcnt", rd_count, 5);
        preload(16'h0021, 6);
        bus.m_ready = 1'b0;
        base = pop_d.size();
        d0 = done_cnt;
        pulse_start(16'd6);
        cycles(3);
        bus.m_ready = 1'b1;
        cycles(2);
        r0 = rd_count;
        pulse_start(16'd3);
        chk("ign_mid_busy", busy, 1);
        chk("ign_mid_rdcnt", rd_count, r0 + 1);
        wait_done(d0);
        cycles(1);
        chk_burst("ign", base, 6, 16'h0021);
        chk("ign_rdcnt", rd_count, 6);

        // reset mid-burst
        preload(16'h0031, 6);
        base = pop_d.size();
        d0 = done_cnt;
        pulse_start(16'd6);
        n = 0;
        while (pop_d.size() - base < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstm_reach3", pop_d.size() - base, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_valid", bus.m_valid, 0);
        chk("rstm_rden", bus.fifo_rd_en, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_rdcnt", rd_count, 0);
        cycles(5);
        chk("rstm_no_done", done_cnt - d0, 0);
        chk("rstm_still_idle", busy, 0);
        fifo_q.delete();

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
        chk("uf_init", err_underflow, 0);
        preload(16'h0041, 2);
        d0 = done_cnt;
        start = 1'b1;
        burst_len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        burst_len = '0;
        n = 0;
        while (!bus.fifo_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.fifo_underflow = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.fifo_underflow = 1'b0;
        wait_done(d0);
        cycles(1);
        chk("uf_flag", err_underflow, 1);
        chk("uf_cnt", err_cnt, 1);
        chk("uf_rdcnt", rd_count, 2);
        cycles(10);
        chk("uf_sticky", err_underflow, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("uf_clr_flag", err_underflow, 0);
        chk("uf_clr_cnt", err_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
